alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU/branch-compare datapath between NUM_REQ requesters, e.g. the execute stage, the CSR/atomic unit and the address-generation helper.
- Arbitrates round-robin, drives the ALU operand ports, and captures each result into a per-requester response register.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Fixed one-cycle latency from accept to response.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- IDX_W, 2, width of the grant index; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester request accepted this cycle when valid&ready
- req_exe_fun  input  NUM_REQ*5  per-requester operation code (ALU_* / BR_* encodings)
- req_op1  input  NUM_REQ*32  per-requester operand 1
- req_op2  input  NUM_REQ*32  per-requester operand 2
- resp_valid  output  NUM_REQ  per-requester response valid
- resp_ready  input  NUM_REQ  per-requester response consumed
- resp_data  output  NUM_REQ*32  captured alu_out
- resp_branch  output  NUM_REQ  captured branch_take
- alu_exe_fun  output  5  to shared ALU
- alu_op1  output  32  to shared ALU
- alu_op2  output  32  to shared ALU
- alu_out  input  32  from shared ALU (combinational)
- alu_branch_take  input  1  from shared ALU (combinational)
- grant_idx  output  IDX_W  requester granted this cycle; debug/perf only

Behaviour:
- Reset is asynchronous and active-high.
  - resp_valid=0, resp_data=0, resp_branch=0, last_grant pointer = NUM_REQ-1, lock state cleared.
  - req_ready is 0 while reset is asserted.
- Eligibility: requester i is eligible when req_valid[i] && (!resp_valid[i] || resp_ready[i]). Its response slot must be free or be drained in the same cycle.
- Arbitration:
  - Round-robin among eligible requesters, searching from last_grant+1 upward with wrap-around.
  - At most one grant per cycle.
  - req_ready[i]=1 only for the granted i.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Requester rule: once req_valid is asserted, it and its payload stay stable until accepted. Checked by assertion in the bench.
- ALU drive:
  - alu_exe_fun/op1/op2 carry the granted requester's payload.
  - With no grant they carry zeros, i.e. op 0 / 0 / 0; the consumer ignores them.
- Accept (valid&ready on requester i) at edge N:
  - resp_data[i] <= alu_out and resp_branch[i] <= alu_branch_take.
  - resp_valid[i] = 1 from cycle N+1.
  - last_grant <= i.
- Response:
  - resp_valid[i] clears on resp_ready[i] unless a new accept for i happens in the same cycle.
  - In that case the register is overwritten and stays valid, giving back-to-back throughput of one op per cycle per requester.
  - Response data is held stable while resp_valid && !resp_ready.
- No grant when nothing is eligible; last_grant is unchanged.
- Simultaneous requests from all NUM_REQ requesters, responses always ready: each requester is granted once every NUM_REQ cycles. No starvation.
- A response stalled indefinitely blocks only its own requester; others continue.
- Reset mid-operation drops pending responses with no further side effects.
- grant_idx holds the current grant when valid; otherwise it holds last_grant.

Optional Feature:
- Macro ALU_SHARE_ARB_LOCK_EN adds input req_lock[NUM_REQ].
- With the macro:
  - If a requester is accepted with req_lock=1, the arbiter locks to it.
  - Only that requester is eligible until it is accepted with req_lock=0, which releases the lock after that accept.
  - This supports atomic read-modify-write sequences needing consecutive ALU ops.
  - Reset clears the lock.
- Without the macro: the port is absent and plain round-robin always applies.

Test Plan:
- Single requester 0 sends ALU_ADD op1=5 op2=7 -> accept in cycle 0, resp_valid[0]=1 in cycle 1, resp_data[0]=12.
- Requesters 0 and 1 both sending every cycle with resp_ready=1 (req0 ALU_SUB 10,3; req1 ALU_XOR 0xF0,0x0F) -> grants alternate 0,1,0,1…; results 7 and 0xFF respectively.
- resp_ready[0]=0 for 5 cycles after a result 0x1234 -> resp_data[0] stays 0x1234, req_ready[0]=0, requester 1 still granted every cycle it is valid.
- Requester 1 sends BR_BLT op1=0xFFFFFFFF op2=1 -> resp_branch[1]=1; BR_BLTU with the same operands -> resp_branch[1]=0.
- Reset asserted between accept and response -> resp_valid all 0 immediately (asynchronous), last_grant=NUM_REQ-1; after release, first grant goes to requester 0.
- (LOCK_EN) Requester 1 issues 3 ops with req_lock=1,1,0 while requester 0 is continuously valid -> grants 1,1,1, then 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU/branch-compare
// datapath between NUM_REQ requesters.
// Each accepted request is answered one cycle later from a per-requester
// response register.
// Optional feature: define ALU_SHARE_ARB_LOCK_EN to add req_lock. A requester
// accepted with req_lock=1 keeps exclusive access until it is accepted with
// req_lock=0.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_exe_fun,
  input  logic [NUM_REQ*32-1:0]   req_op1,
  input  logic [NUM_REQ*32-1:0]   req_op2,
`ifdef ALU_SHARE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]      req_lock,
`endif
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [NUM_REQ*32-1:0]   resp_data,
  output logic [NUM_REQ-1:0]      resp_branch,
  output logic [4:0]              alu_exe_fun,
  output logic [31:0]             alu_op1,
  output logic [31:0]             alu_op2,
  input  logic [31:0]             alu_out,
  input  logic                    alu_branch_take,
  output logic [IDX_W-1:0]        grant_idx
);

  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [NUM_REQ-1:0]    resp_branch_q, resp_branch_d;
  logic [NUM_REQ*32-1:0] resp_data_q, resp_data_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    gnt;
  logic                  grant_valid;
  logic [IDX_W-1:0]      grant_sel;

`ifdef ALU_SHARE_ARB_LOCK_EN
  logic                  lock_q, lock_d;
  logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
`endif

  // A requester may be granted only if its response slot is free or drains now.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (!resp_valid_q[i] || resp_ready[i]) && !reset;
`ifdef ALU_SHARE_ARB_LOCK_EN
      if (lock_q && (lock_idx_q != IDX_W'(i))) begin
        eligible[i] = 1'b0;
      end
`endif
    end
  end

  // Round-robin pick: lowest eligible index above last_grant, else lowest overall.
  always_comb begin
    logic             hi_valid, lo_valid;
    logic [IDX_W-1:0] hi_sel, lo_sel;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    // Descending scan so the lowest matching index is assigned last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_valid = 1'b1;
        lo_sel   = IDX_W'(i);
        if (IDX_W'(i) > last_grant_q) begin
          hi_valid = 1'b1;
          hi_sel   = IDX_W'(i);
        end
      end
    end
    grant_valid = hi_valid || lo_valid;
    grant_sel   = hi_valid ? hi_sel : lo_sel;
  end

  // One-hot grant, request handshake and shared ALU operand mux.
  always_comb begin
    gnt         = '0;
    alu_exe_fun = '0;
    alu_op1     = '0;
    alu_op2     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_valid && (grant_sel == IDX_W'(i))) begin
        gnt[i]      = 1'b1;
        alu_exe_fun = req_exe_fun[i*5 +: 5];
        alu_op1     = req_op1[i*32 +: 32];
        alu_op2     = req_op2[i*32 +: 32];
      end
    end
    req_ready = gnt;
    grant_idx = grant_valid ? grant_sel : last_grant_q;
  end

  // Next state: capture ALU result on accept, otherwise drain on resp_ready.
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_branch_d = resp_branch_q;
    resp_data_d   = resp_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        resp_valid_d[i]          = 1'b1;
        resp_branch_d[i]         = alu_branch_take;
        resp_data_d[i*32 +: 32]  = alu_out;
      end else if (resp_ready[i]) begin
        resp_valid_d[i] = 1'b0;
      end
    end
    last_grant_d = grant_valid ? grant_sel : last_grant_q;
`ifdef ALU_SHARE_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    // The lock follows the req_lock bit of every accepted op.
    if (grant_valid) begin
      lock_d     = |(gnt & req_lock);
      lock_idx_d = grant_sel;
    end
`endif
  end

  // State registers; reset drops any pending responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q  <= '0;
      resp_branch_q <= '0;
      resp_data_q   <= '0;
      last_grant_q  <= IDX_W'(NUM_REQ - 1);
`ifdef ALU_SHARE_ARB_LOCK_EN
      lock_q        <= 1'b0;
      lock_idx_q    <= '0;
`endif
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_branch_q <= resp_branch_d;
      resp_data_q   <= resp_data_d;
      last_grant_q  <= last_grant_d;
`ifdef ALU_SHARE_ARB_LOCK_EN
      lock_q        <= lock_d;
      lock_idx_q    <= lock_idx_d;
`endif
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_branch = resp_branch_q;

endmodule
